// File: rtl/ram_access_arbiter.sv
// Two-port round-robin arbiter in front of an internal single-port RAM.
// One access is in flight at a time; reads hold their response until the owner accepts it.
module ram_access_arbiter #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req0_valid,
   output logic                  req0_ready,
   input  logic                  req0_we,
   input  logic [ADDR_WIDTH-1:0] req0_addr,
   input  logic [DATA_WIDTH-1:0] req0_wdata,
   output logic                  rsp0_valid,
   input  logic                  rsp0_ready,
   output logic [DATA_WIDTH-1:0] rsp0_rdata,
   input  logic                  req1_valid,
   output logic                  req1_ready,
   input  logic                  req1_we,
   input  logic [ADDR_WIDTH-1:0] req1_addr,
   input  logic [DATA_WIDTH-1:0] req1_wdata,
   output logic                  rsp1_valid,
   input  logic                  rsp1_ready,
   output logic [DATA_WIDTH-1:0] rsp1_rdata,
   output logic                  busy
);

   localparam int DEPTH = 2 ** ADDR_WIDTH;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_t;

   state_t                r_state;
   state_t                w_nextState;
   logic                  r_lastGrant;
   logic                  r_owner;
   logic                  r_we;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [DATA_WIDTH-1:0] r_wdata;
   logic [DATA_WIDTH-1:0] r_rdata;
   logic [DATA_WIDTH-1:0] r_mem [DEPTH];
   logic                  w_grant0;
   logic                  w_grant1;
   logic                  w_accept;
   logic                  w_rspTaken;

   // On a tie the port that was not granted last wins.
   always_comb begin
      w_grant0 = 1'b0;
      w_grant1 = 1'b0;
      if (r_state == IDLE) begin
         if (req0_valid && req1_valid) begin
            w_grant0 = r_lastGrant;
            w_grant1 = ~r_lastGrant;
         end else begin
            w_grant0 = req0_valid;
            w_grant1 = req1_valid;
         end
      end
   end

   assign w_accept   = w_grant0 | w_grant1;
   assign w_rspTaken = r_owner ? rsp1_ready : rsp0_ready;

   always_comb begin
      w_nextState = r_state;
      case (r_state)
         IDLE:    if (w_accept) w_nextState = ACCESS;
         ACCESS:  w_nextState = r_we ? IDLE : RESP;
         RESP:    if (w_rspTaken) w_nextState = IDLE;
         default: w_nextState = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_lastGrant <= 1'b1;
         r_owner     <= 1'b0;
         r_we        <= 1'b0;
         r_addr      <= '0;
         r_wdata     <= '0;
      end else if (w_accept) begin
         r_lastGrant <= w_grant1;
         r_owner     <= w_grant1;
         r_we        <= w_grant1 ? req1_we    : req0_we;
         r_addr      <= w_grant1 ? req1_addr  : req0_addr;
         r_wdata     <= w_grant1 ? req1_wdata : req0_wdata;
      end
   end

   // Writes commit here, so any later grant already sees the new word.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
      end else if (r_state == ACCESS && r_we) begin
         r_mem[r_addr] <= r_wdata;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rdata <= '0;
      end else if (r_state == ACCESS && !r_we) begin
         r_rdata <= r_mem[r_addr];
      end
   end

   assign req0_ready = w_grant0;
   assign req1_ready = w_grant1;
   assign rsp0_valid = (r_state == RESP) && !r_owner;
   assign rsp1_valid = (r_state == RESP) && r_owner;
   assign rsp0_rdata = r_rdata;
   assign rsp1_rdata = r_rdata;
   assign busy       = (r_state != IDLE);

endmodule

// File: tb/tb_ram_access_arbiter.sv
// Bench for ram_access_arbiter: a cycle table, directed corner sequences,
// and a randomized run scored against a transaction-level model of the arbiter.
`timescale 1ns/1ps
module tb_ram_access_arbiter;

   logic       clk = 1'b0;
   logic       rst;
   logic       req0_valid, req0_ready, req0_we;
   logic [1:0] req0_addr;
   logic [7:0] req0_wdata;
   logic       rsp0_valid, rsp0_ready;
   logic [7:0] rsp0_rdata;
   logic       req1_valid, req1_ready, req1_we;
   logic [1:0] req1_addr;
   logic [7:0] req1_wdata;
   logic       rsp1_valid, rsp1_ready;
   logic [7:0] rsp1_rdata;
   logic       busy;

   int nChecks = 0;
   int nPass   = 0;

   typedef struct {
      int v0, we0, a0, d0;
      int v1, we1, a1, d1;
      int rr0, rr1;
      int eRdy0, eRdy1, eRv0, eRv1, eRd, eBusy;
   } vec_t;

   vec_t vecs [21];

   ram_access_arbiter #(.DATA_WIDTH(8), .ADDR_WIDTH(2)) dut (
      .clk        (clk),
      .rst        (rst),
      .req0_valid (req0_valid),
      .req0_ready (req0_ready),
      .req0_we    (req0_we),
      .req0_addr  (req0_addr),
      .req0_wdata (req0_wdata),
      .rsp0_valid (rsp0_valid),
      .rsp0_ready (rsp0_ready),
      .rsp0_rdata (rsp0_rdata),
      .req1_valid (req1_valid),
      .req1_ready (req1_ready),
      .req1_we    (req1_we),
      .req1_addr  (req1_addr),
      .req1_wdata (req1_wdata),
      .rsp1_valid (rsp1_valid),
      .rsp1_ready (rsp1_ready),
      .rsp1_rdata (rsp1_rdata),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   // Every task starts and ends one time unit after a rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string name, input int act, input int exp);
      nChecks++;
      if (act == exp) begin
         nPass++;
      end else begin
         $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   function automatic int reqReady(input int port);
      return (port == 0) ? int'(req0_ready) : int'(req1_ready);
   endfunction

   function automatic int rspValid(input int port);
      return (port == 0) ? int'(rsp0_valid) : int'(rsp1_valid);
   endfunction

   function automatic int rspData(input int port);
      return (port == 0) ? int'(rsp0_rdata) : int'(rsp1_rdata);
   endfunction

   task automatic driveReq(input int port, input int v, input int we, input int addr, input int data);
      if (port == 0) begin
         req0_valid = (v != 0);
         req0_we    = (we != 0);
         req0_addr  = 2'(addr);
         req0_wdata = 8'(data);
      end else begin
         req1_valid = (v != 0);
         req1_we    = (we != 0);
         req1_addr  = 2'(addr);
         req1_wdata = 8'(data);
      end
   endtask

   task automatic applyStimulus(input vec_t v);
      driveReq(0, v.v0, v.we0, v.a0, v.d0);
      driveReq(1, v.v1, v.we1, v.a1, v.d1);
      rsp0_ready = (v.rr0 != 0);
      rsp1_ready = (v.rr1 != 0);
   endtask

   task automatic resetDut(input string name);
      rst = 1'b1;
      driveReq(0, 0, 0, 0, 0);
      driveReq(1, 0, 0, 0, 0);
      rsp0_ready = 1'b0;
      rsp1_ready = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      #1;
      checkOutput({name, " busy"},   int'(busy), 0);
      checkOutput({name, " ready0"}, int'(req0_ready), 0);
      checkOutput({name, " ready1"}, int'(req1_ready), 0);
      checkOutput({name, " rv0"},    int'(rsp0_valid), 0);
      checkOutput({name, " rv1"},    int'(rsp1_valid), 0);
      checkOutput({name, " rdata0"}, int'(rsp0_rdata), 0);
      checkOutput({name, " rdata1"}, int'(rsp1_rdata), 0);
      tick();
   endtask

   // Full read transaction with the expected two-cycle data latency.
   task automatic doRead(input int port, input int addr, input int expData, input string name);
      int  waitCnt;
      bit  got;
      driveReq(port, 1, 0, addr, 0);
      rsp0_ready = 1'b1;
      rsp1_ready = 1'b1;
      waitCnt = 0;
      got = 1'b0;
      #1;
      while (!got && waitCnt < 20) begin
         if (reqReady(port) == 1) begin
            got = 1'b1;
         end else begin
            tick();
            #1;
            waitCnt++;
         end
      end
      if (!got) begin
         nChecks++;
         $display("[TB] FAIL %s handshake: got no ready, expected ready within 20 cycles", name);
      end
      tick();
      driveReq(port, 0, 0, 0, 0);
      #1;
      checkOutput({name, " no early rsp"}, rspValid(port), 0);
      tick();
      #1;
      checkOutput({name, " rsp valid"}, rspValid(port), 1);
      checkOutput({name, " rsp data"},  rspData(port), expData);
      checkOutput({name, " other rsp"}, rspValid(1 - port), 0);
      tick();
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout, expected $finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int   mMem [4];
      int   mLast, mOwner, mData, win;
      bit   mAccPending, mAccIsRead, mInResp, idle, ownerReady;
      bit   pV [2];
      int   pWe [2], pA [2], pD [2];

      vecs = '{
         '{1,0,2,0,    0,0,0,0, 1,1, 1,0,0,0,0,0},
         '{0,0,0,0,    0,0,0,0, 1,1, 0,0,0,0,0,1},
         '{0,0,0,0,    0,0,0,0, 1,1, 0,0,1,0,0,1},
         '{1,1,1,'hA5, 0,0,0,0, 1,1, 1,0,0,0,0,0},
         '{0,0,0,0,    1,0,1,0, 1,1, 0,0,0,0,0,1},
         '{0,0,0,0,    1,0,1,0, 1,1, 0,1,0,0,0,0},
         '{0,0,0,0,    0,0,0,0, 1,1, 0,0,0,0,0,1},
         '{0,0,0,0,    0,0,0,0, 1,1, 0,0,0,1,'hA5,1},
         '{1,0,1,0,    1,0,0,0, 1,1, 1,0,0,0,0,0},
         '{1,0,1,0,    1,0,0,0, 1,1, 0,0,0,0,0,1},
         '{1,0,1,0,    1,0,0,0, 1,1, 0,0,1,0,'hA5,1},
         '{1,0,1,0,    1,0,0,0, 1,1, 0,1,0,0,0,0},
         '{1,0,1,0,    1,0,0,0, 1,1, 0,0,0,0,0,1},
         '{1,0,1,0,    1,0,0,0, 1,1, 0,0,0,1,0,1},
         '{1,0,1,0,    1,0,0,0, 1,1, 1,0,0,0,0,0},
         '{1,0,1,0,    1,0,0,0, 1,1, 0,0,0,0,0,1},
         '{1,0,1,0,    1,0,0,0, 1,1, 0,0,1,0,'hA5,1},
         '{1,0,1,0,    1,0,0,0, 1,1, 0,1,0,0,0,0},
         '{0,0,0,0,    0,0,0,0, 1,1, 0,0,0,0,0,1},
         '{0,0,0,0,    0,0,0,0, 1,1, 0,0,0,1,0,1},
         '{0,0,0,0,    0,0,0,0, 1,1, 0,0,0,0,0,0}
      };

      resetDut("reset");

      // Reset read, write-then-read across ports, alternating grants.
      for (int i = 0; i < 21; i++) begin
         applyStimulus(vecs[i]);
         #1;
         checkOutput($sformatf("vec%0d ready0", i), int'(req0_ready), vecs[i].eRdy0);
         checkOutput($sformatf("vec%0d ready1", i), int'(req1_ready), vecs[i].eRdy1);
         checkOutput($sformatf("vec%0d rv0", i),    int'(rsp0_valid), vecs[i].eRv0);
         checkOutput($sformatf("vec%0d rv1", i),    int'(rsp1_valid), vecs[i].eRv1);
         checkOutput($sformatf("vec%0d busy", i),   int'(busy),       vecs[i].eBusy);
         if (vecs[i].eRv0 != 0) checkOutput($sformatf("vec%0d rdata0", i), int'(rsp0_rdata), vecs[i].eRd);
         if (vecs[i].eRv1 != 0) checkOutput($sformatf("vec%0d rdata1", i), int'(rsp1_rdata), vecs[i].eRd);
         tick();
      end

      // Response backpressure on port 1 stalls port 0.
      driveReq(1, 1, 0, 1, 0);
      rsp1_ready = 1'b0;
      rsp0_ready = 1'b1;
      #1;
      checkOutput("bp grant1", reqReady(1), 1);
      tick();
      driveReq(1, 0, 0, 0, 0);
      driveReq(0, 1, 0, 2, 0);
      #1;
      checkOutput("bp access ready0", reqReady(0), 0);
      tick();
      for (int i = 0; i < 5; i++) begin
         #1;
         checkOutput($sformatf("bp hold%0d rv1", i),    rspValid(1), 1);
         checkOutput($sformatf("bp hold%0d rdata1", i), rspData(1), 'hA5);
         checkOutput($sformatf("bp hold%0d ready0", i), reqReady(0), 0);
         checkOutput($sformatf("bp hold%0d rv0", i),    rspValid(0), 0);
         tick();
      end
      rsp1_ready = 1'b1;
      #1;
      checkOutput("bp release rv1", rspValid(1), 1);
      checkOutput("bp release ready0", reqReady(0), 0);
      tick();
      #1;
      checkOutput("bp after rv1", rspValid(1), 0);
      checkOutput("bp after ready0", reqReady(0), 1);
      tick();
      driveReq(0, 0, 0, 0, 0);
      tick();
      #1;
      checkOutput("bp port0 rsp", rspValid(0), 1);
      checkOutput("bp port0 data", rspData(0), 0);
      tick();

      // Back-to-back writes to one address, two cycles apart.
      driveReq(0, 1, 1, 3, 'h3C);
      #1;
      checkOutput("wr1 ready", reqReady(0), 1);
      tick();
      driveReq(0, 1, 1, 3, 'h7E);
      #1;
      checkOutput("wr1 access ready", reqReady(0), 0);
      checkOutput("wr1 access busy", int'(busy), 1);
      tick();
      #1;
      checkOutput("wr2 ready", reqReady(0), 1);
      checkOutput("wr2 busy", int'(busy), 0);
      tick();
      driveReq(0, 0, 0, 0, 0);
      #1;
      checkOutput("wr2 access busy", int'(busy), 1);
      tick();
      doRead(1, 3, 'h7E, "wr readback");

      // Reset in the middle of a held response.
      driveReq(1, 1, 0, 3, 0);
      rsp1_ready = 1'b0;
      #1;
      checkOutput("rst grant1", reqReady(1), 1);
      tick();
      driveReq(1, 0, 0, 0, 0);
      tick();
      #1;
      checkOutput("rst pre rv1", rspValid(1), 1);
      checkOutput("rst pre data", rspData(1), 'h7E);
      #2;
      rst = 1'b1;
      #1;
      checkOutput("rst rv1", rspValid(1), 0);
      checkOutput("rst rv0", rspValid(0), 0);
      checkOutput("rst busy", int'(busy), 0);
      checkOutput("rst rdata1", rspData(1), 0);
      tick();
      rst = 1'b0;
      for (int a = 0; a < 4; a++) begin
         doRead(0, a, 0, $sformatf("rst ram%0d", a));
      end

      // Randomized traffic against a transaction-level model.
      resetDut("rnd reset");
      for (int a = 0; a < 4; a++) mMem[a] = 0;
      mLast = 1;
      mOwner = 0;
      mData = 0;
      mAccPending = 1'b0;
      mAccIsRead = 1'b0;
      mInResp = 1'b0;
      pV[0] = 1'b0;
      pV[1] = 1'b0;
      for (int cyc = 0; cyc < 400; cyc++) begin
         for (int p = 0; p < 2; p++) begin
            if (!pV[p] && $urandom_range(2) == 0) begin
               pV[p]  = 1'b1;
               pWe[p] = int'($urandom_range(1));
               pA[p]  = int'($urandom_range(3));
               pD[p]  = int'($urandom_range(255));
            end
         end
         driveReq(0, int'(pV[0]), pWe[0], pA[0], pD[0]);
         driveReq(1, int'(pV[1]), pWe[1], pA[1], pD[1]);
         rsp0_ready = ($urandom_range(1) == 1);
         rsp1_ready = ($urandom_range(1) == 1);
         #1;
         idle = !mAccPending && !mInResp;
         win = -1;
         if (idle) begin
            if (pV[0] && pV[1]) win = (mLast == 1) ? 0 : 1;
            else if (pV[0])     win = 0;
            else if (pV[1])     win = 1;
         end
         checkOutput($sformatf("rnd%0d ready0", cyc), int'(req0_ready), int'(win == 0));
         checkOutput($sformatf("rnd%0d ready1", cyc), int'(req1_ready), int'(win == 1));
         checkOutput($sformatf("rnd%0d busy", cyc),   int'(busy),       int'(!idle));
         checkOutput($sformatf("rnd%0d rv0", cyc),    int'(rsp0_valid), int'(mInResp && mOwner == 0));
         checkOutput($sformatf("rnd%0d rv1", cyc),    int'(rsp1_valid), int'(mInResp && mOwner == 1));
         if (mInResp) checkOutput($sformatf("rnd%0d rdata", cyc), rspData(mOwner), mData);
         ownerReady = (mOwner == 0) ? rsp0_ready : rsp1_ready;
         if (mInResp) begin
            if (ownerReady) mInResp = 1'b0;
         end else if (mAccPending) begin
            mAccPending = 1'b0;
            mInResp = mAccIsRead;
         end else if (win >= 0) begin
            mLast = win;
            mOwner = win;
            mAccIsRead = (pWe[win] == 0);
            if (pWe[win] != 0) mMem[pA[win]] = pD[win];
            else               mData = mMem[pA[win]];
            mAccPending = 1'b1;
            pV[win] = 1'b0;
         end
         tick();
      end

      $display("%0d/%0d checks passed", nPass, nChecks);
      $finish;
   end

endmodule
